// File: rtl/key_led_pkg.sv
// Shared types and helpers for the multi-channel key/LED controller.
package key_led_pkg;

    // LED channel state; encoding 2'd3 is unused and behaves as OFF.
    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2
    } led_state_e;

    // Pin level that means "pressed" for the given key polarity.
    function automatic logic press_level(input int key_active_low);
        return (key_active_low != 0) ? 1'b0 : 1'b1;
    endfunction

    // Counter width for a modulus, never narrower than one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

    // LED state transition for one channel given this cycle's events.
    function automatic led_state_e led_next(input led_state_e cur,
                                            input logic       short_evt,
                                            input logic       long_evt);
        led_state_e nxt;
        case (cur)
            LED_ON: begin
                if (short_evt)     nxt = LED_OFF;
                else if (long_evt) nxt = LED_BLINK;
                else               nxt = LED_ON;
            end
            LED_BLINK: begin
                if (short_evt || long_evt) nxt = LED_OFF;
                else                       nxt = LED_BLINK;
            end
            default: begin
                if (short_evt)     nxt = LED_ON;
                else if (long_evt) nxt = LED_BLINK;
                else               nxt = LED_OFF;
            end
        endcase
        return nxt;
    endfunction

    // LED pin value for a state and the shared blink phase.
    function automatic logic led_drive(input led_state_e s, input logic phase);
        return (s == LED_ON) || ((s == LED_BLINK) && phase);
    endfunction

endpackage

// File: rtl/multi_key_led_ctrl_if.sv
// Key pins in, LED drive and per-channel key events out.
interface multi_key_led_ctrl_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] key;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] key_level;
    logic [N_CH-1:0] key_press;
    logic [N_CH-1:0] key_long;

    modport master (output key, input  led, key_level, key_press, key_long);
    modport slave  (input  key, output led, key_level, key_press, key_long);
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, debounce, and short/long press classification.
module key_debounce_ch
    import key_led_pkg::*;
#(
    parameter int DEB_CYC        = 1_000_000,
    parameter int LONG_CYC       = 50_000_000,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_level,
    output logic key_press,
    output logic key_long,
    output logic short_evt
);
    localparam int             DW        = cnt_width(DEB_CYC);
    localparam int             HW        = cnt_width(LONG_CYC);
    localparam logic           PRESS     = press_level(KEY_ACTIVE_LOW);
    localparam logic [DW-1:0]  DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYC - 1);

    logic          sync_a;
    logic          sync_b;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic          long_done;
    logic          pressed;
    logic          differ;
    logic          flip;

    assign pressed = (sync_b == PRESS);
    assign differ  = (pressed != key_level);
    assign flip    = differ && (deb_cnt == DEB_LAST);

    // Two-flop synchroniser; resets to the released pin level so reset exit never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments make sync_b take sync_a's pre-edge value, giving two real stages.
        if (!rst) begin
            sync_a <= ~PRESS;
            sync_b <= ~PRESS;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
        end
    end

    // Debounce the synchronised level, then time the hold and emit press/long/short pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            key_level <= 1'b0;
            key_press <= 1'b0;
            key_long  <= 1'b0;
            short_evt <= 1'b0;
        end else begin
            key_press <= 1'b0;
            key_long  <= 1'b0;
            short_evt <= 1'b0;

            if (!differ) begin
                deb_cnt <= '0;
            end else if (flip) begin
                deb_cnt   <= '0;
                key_level <= pressed;
                hold_cnt  <= '0;
                long_done <= 1'b0;
                if (pressed) key_press <= 1'b1;
                else         short_evt <= ~long_done;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            // A release on this edge takes priority over reaching the long threshold.
            if (key_level && !flip && !long_done) begin
                if (hold_cnt == HOLD_LAST) begin
                    key_long  <= 1'b1;
                    long_done <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/multi_key_led_ctrl.sv
// N-channel key debouncer with short/long press LED control (OFF/ON/BLINK).
module multi_key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int DEB_CYC        = 1_000_000,
    parameter int LONG_CYC       = 50_000_000,
    parameter int BLINK_CYC      = 12_500_000,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_key_led_ctrl_if.slave  bus
);
    localparam int            PW         = cnt_width(BLINK_CYC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(BLINK_CYC - 1);

    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] long_evt;
    logic [N_CH-1:0] short_evt;
    logic [N_CH-1:0] led;
    led_state_e      state [N_CH];

    logic [PW-1:0]   presc;
    logic            blink_phase;
    logic            phase_next;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYC        (DEB_CYC),
            .LONG_CYC       (LONG_CYC),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .key       (bus.key[i]),
            .key_level (level[i]),
            .key_press (press[i]),
            .key_long  (long_evt[i]),
            .short_evt (short_evt[i])
        );
    end

    assign bus.key_level = level;
    assign bus.key_press = press;
    assign bus.key_long  = long_evt;
    assign bus.led       = led;

    // Phase after this edge, so the registered LED tracks the phase register exactly.
    assign phase_next = blink_phase ^ (presc == PRESC_LAST);

    // Free-running shared blink prescaler; all blinking channels stay in phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc       <= '0;
            blink_phase <= 1'b0;
        end else begin
            presc       <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            blink_phase <= phase_next;
        end
    end

    // Per-channel LED FSMs with registered LED drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the state array is a bank of flops, not a RAM, so every entry gets an explicit reset.
            for (int i = 0; i < N_CH; i++) state[i] <= LED_OFF;
            led <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= led_next(state[i], short_evt[i], long_evt[i]);
                led[i]   <= led_drive(led_next(state[i], short_evt[i], long_evt[i]), phase_next);
            end
        end
    end
endmodule

// File: tb/tb_multi_key_led_ctrl.sv
// Bench for multi_key_led_ctrl: cycle-by-cycle behavioural model plus directed scenarios.
module tb_multi_key_led_ctrl;
    localparam int N_CH      = 2;
    localparam int DEB_CYC   = 4;
    localparam int LONG_CYC  = 16;
    localparam int BLINK_CYC = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    multi_key_led_ctrl_if #(.N_CH(N_CH)) bus ();

    multi_key_led_ctrl #(
        .N_CH           (N_CH),
        .DEB_CYC        (DEB_CYC),
        .LONG_CYC       (LONG_CYC),
        .BLINK_CYC      (BLINK_CYC),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Pin samples per edge (1 = pressed); the level flips once the four samples
    // taken 2..5 edges ago all disagree with it (two sync stages + DEB_CYC window).
    bit   hist [N_CH][6];
    logic [N_CH-1:0] m_level, m_press, m_long, m_short, m_fired, m_led;
    int   m_age [N_CH];
    int   m_st  [N_CH];   // 0 off, 1 on, 2 blink
    int   m_edges;

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < 6; k++) hist[c][k] = 1'b0;
            m_age[c] = 0;
            m_st[c]  = 0;
        end
        m_level = '0; m_press = '0; m_long = '0; m_short = '0; m_fired = '0; m_led = '0;
        m_edges = 0;
    endtask

    task automatic model_step();
        bit phase;
        bit flip;
        m_edges++;
        phase = ((m_edges / BLINK_CYC) % 2) == 1;
        for (int c = 0; c < N_CH; c++) begin
            if (m_short[c])     m_st[c] = (m_st[c] == 0) ? 1 : 0;
            else if (m_long[c]) m_st[c] = (m_st[c] == 2) ? 0 : 2;
            for (int k = 5; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = (bus.key[c] == 1'b0);
            flip = 1'b1;
            for (int k = 2; k < 6; k++) if (hist[c][k] == m_level[c]) flip = 1'b0;
            m_press[c] = 1'b0; m_long[c] = 1'b0; m_short[c] = 1'b0;
            if (flip) begin
                m_level[c] = ~m_level[c];
                if (m_level[c]) begin
                    m_press[c] = 1'b1;
                    m_age[c]   = 0;
                end else begin
                    m_short[c] = ~m_fired[c];
                end
                m_fired[c] = 1'b0;
            end else if (m_level[c] && !m_fired[c]) begin
                m_age[c]++;
                if (m_age[c] == LONG_CYC) begin
                    m_long[c]  = 1'b1;
                    m_fired[c] = 1'b1;
                end
            end
            m_led[c] = (m_st[c] == 1) || (m_st[c] == 2 && phase);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("model_level", bus.key_level, m_level);
            check("model_press", bus.key_press, m_press);
            check("model_long",  bus.key_long,  m_long);
            check("model_led",   bus.led,       m_led);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [N_CH-1:0] seen_level, seen_press, seen_long;

    task automatic tick();
        @(negedge clk);
        seen_level |= bus.key_level;
        seen_press |= bus.key_press;
        seen_long  |= bus.key_long;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_seen();
        seen_level = '0; seen_press = '0; seen_long = '0;
    endtask

    // Falling edges until a press (is_long=0) or long (is_long=1) pulse on ch; -1 on timeout.
    task automatic wait_pulse(input int ch, input bit is_long, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if ((is_long ? bus.key_long[ch] : bus.key_press[ch]) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    int   n, n2, last_change, changes;
    logic prev, led_before, saw0, saw1;

    initial begin
        bus.key = 2'b11;
        clear_seen();

        // 1: long reset with keys released, then quiet after release
        idle(50);
        check("t1_led_in_rst", bus.led, 0);
        check("t1_level_in_rst", bus.key_level, 0);
        rst = 1'b1;
        clear_seen();
        idle(20);
        check("t1_no_press", seen_press, 0);

        // 2: bounce shorter than the debounce window
        clear_seen();
        for (int r = 0; r < 5; r++) begin
            bus.key[0] = 1'b0; idle(3);
            bus.key[0] = 1'b1; idle(3);
        end
        idle(10);
        check("t2_level_never", seen_level[0], 0);
        check("t2_led", bus.led[0], 0);

        // 3: short press twice toggles ch0 on then off
        for (int r = 0; r < 2; r++) begin
            clear_seen();
            bus.key[0] = 1'b0;
            wait_pulse(0, 1'b0, 20, n);
            check("t3_press_lat", n, 6);
            idle(10 - 6);
            bus.key[0] = 1'b1;
            n2 = -1;
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (bus.key_level[0] == 1'b0) begin n2 = i; break; end
            end
            check("t3_release_seen", n2 > 0, 1);
            led_before = bus.led[0];
            check("t3_led_before", led_before, r);
            tick();
            check("t3_led_after", bus.led[0], (r == 0) ? 1 : 0);
            check("t3_no_long", seen_long, 0);
            idle(5);
        end

        // 4: long hold on ch1 enters BLINK, blinks every 3 cycles, release is silent
        bus.key[1] = 1'b0;
        wait_pulse(1, 1'b0, 20, n);
        check("t4_press_lat", n, 6);
        wait_pulse(1, 1'b1, 30, n2);
        check("t4_long_lat", n2, LONG_CYC);
        tick();
        prev = bus.led[1];
        last_change = -1;
        changes = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.led[1] != prev) begin
                if (last_change >= 0) check("t4_blink_period", i - last_change, BLINK_CYC);
                last_change = i;
                changes++;
                prev = bus.led[1];
            end
        end
        check("t4_blink_toggles", changes >= 4, 1);
        idle(2);
        bus.key[1] = 1'b1;
        idle(20);
        bus.key[1] = 1'b0;
        wait_pulse(1, 1'b1, 40, n2);
        check("t4_second_long", n2 > 0, 1);
        idle(3);
        check("t4_led_off", bus.led[1], 0);
        bus.key[1] = 1'b1;
        idle(15);

        // 4b: hold exactly LONG_CYC cycles; the release wins and counts as short
        clear_seen();
        bus.key[1] = 1'b0;
        idle(LONG_CYC);
        bus.key[1] = 1'b1;
        idle(25);
        check("t4b_no_long", seen_long[1], 0);
        check("t4b_led_on", bus.led[1], 1);

        // 5: both channels pressed together; ch0 short, ch1 long
        bus.key = 2'b00;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.key_press != 0) begin n = i; break; end
        end
        check("t5_press_lat", n, 6);
        check("t5_press_both", bus.key_press, 2'b11);
        idle(4);
        bus.key[0] = 1'b1;
        idle(30);
        check("t5_led0_on", bus.led[0], 1);
        saw0 = 1'b0; saw1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.led[1]) saw1 = 1'b1; else saw0 = 1'b0 | 1'b1;
        end
        check("t5_ch1_blinks", saw0 && saw1, 1);
        bus.key[1] = 1'b1;
        idle(20);

        // 6: reset while ch0 blinks with the key held
        clear_seen();
        bus.key[0] = 1'b0;
        idle(30);
        check("t6_long_seen", seen_long[0], 1);
        #2 rst = 1'b0;
        #1 check("t6_led_rst", bus.led, 0);
        check("t6_level_rst", bus.key_level, 0);
        idle(3);
        rst = 1'b1;
        wait_pulse(0, 1'b0, 20, n);
        check("t6_press_after_rst", n, 6);
        bus.key[0] = 1'b1;
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
